// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   uart_state_t        : frame state encoding (IDLE/START/DATA/STOP)
//   OVERSAMPLE_DEFAULT  : baud_tick pulses per bit period
//   frameTicks()        : ticks in one frame for a given frame format
//   FRAME_TICKS_DEFAULT : ticks in one 8N1 frame at the default oversample
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int OVERSAMPLE_DEFAULT = 16;
   localparam int DATA_BITS_DEFAULT  = 8;
   localparam int STOP_BITS_DEFAULT  = 1;

   // One start bit, the payload and the stop bits, each OVERSAMPLE ticks long
   function automatic int frameTicks(input int dataBits, input int stopBits, input int oversample);
      return (1 + dataBits + stopBits) * oversample;
   endfunction

   localparam int FRAME_TICKS_DEFAULT =
      frameTicks(DATA_BITS_DEFAULT, STOP_BITS_DEFAULT, OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Counts baud_tick pulses modulo OVERSAMPLE and flags the tick that closes a
// bit period. Shared by the transmitter and the receiver.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   i_clear   : synchronous clear; holds the count at 0 and masks bit_end
//   i_tick    : one-clk baud_tick strobe
//   o_bit_end : high in the cycle whose tick is the last of a bit period
// ---------------------------------------------------------------------------
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_tick,
   output logic o_bit_end
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] r_count;

   // The bit ends on the tick that would wrap the counter back to zero
   assign o_bit_end = i_tick && !i_clear && (r_count == LAST_TICK);

   // Tick counter: only baud_tick cycles advance it, so gaps between ticks
   // simply hold the current position within the bit
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_tick) begin
         if (r_count == LAST_TICK) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: takes a byte over a valid/ready handshake and sends one
// frame (start bit 0, DATA_BITS data bits MSB first, STOP_BITS stop bits 1)
// timed by the shared 16x baud_tick strobe.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset; aborts any frame in flight
//   i_baud_tick : one-clk strobe at OVERSAMPLE x baud rate
//   i_in_valid  : i_in_data holds a byte to send
//   i_in_data   : byte to send, bit DATA_BITS-1 first
//   o_in_ready  : byte can be accepted this cycle
//   o_tx        : registered serial line, idles high
//   o_busy      : frame in progress
//   o_done      : one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEFAULT,
   parameter int STOP_BITS  = STOP_BITS_DEFAULT,
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_baud_tick,
   input  logic                 i_in_valid,
   input  logic [DATA_BITS-1:0] i_in_data,
   output logic                 o_in_ready,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   // Bit counter is shared between the data bits and the stop bits
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   uart_state_t          r_state;
   uart_state_t          w_nextState;
   logic [DATA_BITS-1:0] r_shiftReg;
   logic [DATA_BITS-1:0] w_shiftNext;
   logic [BW-1:0]        r_bitCount;
   logic [BW-1:0]        w_bitCountNext;
   logic                 r_tx;
   logic                 r_done;
   logic                 w_txNext;
   logic                 w_doneNext;
   logic                 w_bitEnd;
   logic                 w_timerClear;
   logic                 w_accept;
   logic                 w_frameEnd;

   // Timer is held at zero in IDLE, so a tick in the accepting cycle is not
   // counted and the start bit always gets a full OVERSAMPLE ticks
   assign w_timerClear = (r_state == IDLE);

   uart_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bitTimer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_timerClear),
      .i_tick   (i_baud_tick),
      .o_bit_end(w_bitEnd)
   );

   assign w_accept   = (r_state == IDLE) && i_in_valid;
   assign w_frameEnd = (r_state == STOP) && w_bitEnd && (r_bitCount == LAST_STOP);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: every transition happens on a bit boundary except the
   // handshake that leaves IDLE
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_nextState = START;
         START: if (w_bitEnd) w_nextState = DATA;
         DATA:  if (w_bitEnd && (r_bitCount == LAST_DATA)) w_nextState = STOP;
         STOP:  if (w_frameEnd) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Output logic; tx and done are computed one cycle ahead from the next
   // state so that the registered versions line up with that state
   always_comb begin
      o_in_ready = (r_state == IDLE) && !rst;
      o_busy     = (r_state != IDLE);
      w_doneNext = w_frameEnd;
      w_txNext   = 1'b1;
      case (w_nextState)
         IDLE:  w_txNext = 1'b1;
         START: w_txNext = 1'b0;
         DATA:  w_txNext = w_shiftNext[DATA_BITS-1];
         STOP:  w_txNext = 1'b1;
         default: w_txNext = 1'b1;
      endcase
   end

   // Shift register and bit counter next values; the payload leaves MSB
   // first, so the register shifts left at every data bit boundary
   always_comb begin
      w_shiftNext    = r_shiftReg;
      w_bitCountNext = r_bitCount;
      case (r_state)
         IDLE: begin
            w_bitCountNext = '0;
            if (w_accept) w_shiftNext = i_in_data;
         end
         DATA: begin
            if (w_bitEnd) begin
               w_shiftNext    = {r_shiftReg[DATA_BITS-2:0], 1'b0};
               w_bitCountNext = (r_bitCount == LAST_DATA) ? '0 : r_bitCount + 1'b1;
            end
         end
         STOP: begin
            if (w_bitEnd) begin
               w_bitCountNext = (r_bitCount == LAST_STOP) ? '0 : r_bitCount + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and output registers; reset drops the frame immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shiftReg <= '0;
         r_bitCount <= '0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_shiftReg <= w_shiftNext;
         r_bitCount <= w_bitCountNext;
         r_tx       <= w_txNext;
         r_done     <= w_doneNext;
      end
   end

   assign o_tx   = r_tx;
   assign o_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. The driver keeps a frame-level model (ticks remaining in
// the current frame) to predict in_ready/busy/done/idle tx and pushes each
// byte it expects to be accepted into a scoreboard queue. A separate monitor
// watches the tx line, pops a byte at each start bit and checks every bit
// period tick by tick.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int DATA_BITS   = 8;
   localparam int STOP_BITS   = 1;
   localparam int OVERSAMPLE  = 16;
   localparam int FRAME_BITS  = 1 + DATA_BITS + STOP_BITS;
   localparam int FRAME_TICKS = FRAME_BITS * OVERSAMPLE;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       baudTick = 1'b0;
   logic       inValid  = 1'b0;
   logic [7:0] inData   = 8'h00;
   logic       inReady;
   logic       tx;
   logic       busy;
   logic       done;

   uart_tx #(
      .DATA_BITS (DATA_BITS),
      .STOP_BITS (STOP_BITS),
      .OVERSAMPLE(OVERSAMPLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_baud_tick(baudTick),
      .i_in_valid (inValid),
      .i_in_data  (inData),
      .o_in_ready (inReady),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   int         compared    = 0;
   int         mismatched  = 0;
   logic [7:0] expQ[$];
   bit         checkEnable = 1'b0;
   bit         monActive   = 1'b0;

   // Frame-level reference: ticks left in the frame in flight (0 = idle)
   int remaining   = 0;
   bit doneExp     = 1'b0;
   int acceptCount = 0;
   int cyc         = 0;
   int tickPeriod  = 4;
   bit randTicks   = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
      end
   endtask

   // One clock cycle: check outputs against the model, then drive new inputs
   // and advance the model to what the next rising edge should produce
   task automatic applyStimulus(input bit valid, input logic [7:0] data, input bit rstIn);
      bit tick;
      @(negedge clk);
      if (checkEnable) begin
         checkOutput("busy", {31'd0, busy}, {31'd0, remaining != 0});
         checkOutput("done", {31'd0, done}, {31'd0, doneExp});
         checkOutput("in_ready", {31'd0, inReady}, {31'd0, (remaining == 0) && !rst});
         if (remaining == 0) checkOutput("tx_idle", {31'd0, tx}, 32'd1);
      end
      tick     = randTicks ? ($urandom_range(0, 3) == 0) : ((cyc % tickPeriod) == 0);
      baudTick = tick;
      inValid  = valid;
      inData   = data;
      rst      = rstIn;
      if (rstIn) begin
         remaining = 0;
         doneExp   = 1'b0;
      end else if (remaining == 0) begin
         doneExp = 1'b0;
         if (valid) begin
            expQ.push_back(data);
            remaining = FRAME_TICKS;
            acceptCount++;
         end
      end else begin
         doneExp = 1'b0;
         if (tick) begin
            remaining--;
            if (remaining == 0) doneExp = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (remaining != 0 && n < 5000) begin
         applyStimulus(1'b0, 8'($urandom), 1'b0);
         n++;
      end
      if (remaining != 0) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic sendByte(input logic [7:0] data);
      waitIdle();
      applyStimulus(1'b1, data, 1'b0);
   endtask

   // Monitor: acts as a reference receiver on the tx line
   initial begin
      int         tickIdx = 0;
      bit         prevTx  = 1'b1;
      bit         bitBad  = 1'b0;
      logic       badVal  = 1'b0;
      logic       frameBits[FRAME_BITS];
      logic [7:0] b;
      forever begin
         @(negedge clk);
         #1;
         if (!checkEnable) begin
            prevTx = 1'b1;
            continue;
         end
         if (rst) begin
            monActive = 1'b0;
            prevTx    = tx;
            continue;
         end
         if (!monActive && prevTx && !tx) begin
            compared++;
            if (expQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL frame_start: got start bit, expected no frame (t=%0t)", $time);
            end else begin
               b = expQ.pop_front();
               frameBits[0] = 1'b0;
               for (int i = 0; i < DATA_BITS; i++) frameBits[1 + i] = b[DATA_BITS - 1 - i];
               for (int i = 0; i < STOP_BITS; i++) frameBits[1 + DATA_BITS + i] = 1'b1;
               monActive = 1'b1;
               tickIdx   = 0;
               bitBad    = 1'b0;
            end
         end
         if (monActive && baudTick) begin
            if (tx !== frameBits[tickIdx / OVERSAMPLE]) begin
               bitBad = 1'b1;
               badVal = tx;
            end
            if ((tickIdx % OVERSAMPLE) == OVERSAMPLE - 1) begin
               compared++;
               if (bitBad) begin
                  mismatched++;
                  $display("[TB] FAIL frame_bit %0d of byte %0h: got %b, expected %b (t=%0t)",
                           tickIdx / OVERSAMPLE, b, badVal, frameBits[tickIdx / OVERSAMPLE], $time);
               end
               bitBad = 1'b0;
            end
            tickIdx++;
            if (tickIdx == FRAME_TICKS) monActive = 1'b0;
         end
         prevTx = tx;
      end
   end

   // Driver
   initial begin
      int start;
      int n;

      // Reset for two cycles, then idle with ticks running
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkEnable = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1);
      idleCycles(12);

      // Single frame, tick every 4 clocks
      $display("[TB] frame 0xA5");
      sendByte(8'hA5);
      waitIdle();
      idleCycles(3);

      // Back-to-back with in_valid held: second byte taken in the done cycle
      $display("[TB] back-to-back 0x00, 0xFF");
      sendByte(8'h00);
      start = acceptCount;
      n = 0;
      while (acceptCount == start && n < 5000) begin
         applyStimulus(1'b1, 8'hFF, 1'b0);
         n++;
      end
      if (acceptCount == start) checkOutput("b2b_accept_timeout", 32'd1, 32'd0);
      waitIdle();
      idleCycles(2);

      // Valid pulse while busy must be ignored
      $display("[TB] 0xC3 with intruding 0x55");
      sendByte(8'hC3);
      idleCycles(100);
      applyStimulus(1'b1, 8'h55, 1'b0);
      idleCycles(50);
      applyStimulus(1'b1, 8'h55, 1'b0);
      waitIdle();
      idleCycles(2);

      // Reset in the middle of data bit 3, then resend
      $display("[TB] reset during 0x96");
      sendByte(8'h96);
      n = 0;
      while (remaining != 0 && (FRAME_TICKS - remaining) < (4 * OVERSAMPLE + 6) && n < 5000) begin
         applyStimulus(1'b0, 8'($urandom), 1'b0);
         n++;
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      idleCycles(3);
      sendByte(8'h96);
      waitIdle();
      idleCycles(2);

      // Random bytes, irregular ticks, random gaps and stray valids
      $display("[TB] random frames");
      randTicks = 1'b1;
      for (int f = 0; f < 6; f++) begin
         idleCycles($urandom_range(0, 5));
         sendByte(8'($urandom));
         n = 0;
         while (remaining != 0 && n < 5000) begin
            applyStimulus($urandom_range(0, 9) == 0, 8'($urandom), 1'b0);
            n++;
         end
      end
      waitIdle();
      idleCycles(4);

      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      checkOutput("monitor_idle", {31'd0, monActive}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts a parallel byte over a valid/ready handshake and drives it onto the `tx` line as one frame. The frame is one start bit (0), DATA_BITS data bits MSB first, and STOP_BITS stop bits (1). Bit timing comes from the shared 16x-oversampling `baud_tick` strobe, the same strobe the receiver uses, so each bit lasts exactly OVERSAMPLE ticks. Sits between the host/register interface and the pad, and is the transmit counterpart of the team's receiver.

## Interface
- DATA_BITS, 8, payload bits per frame (5..8)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- OVERSAMPLE, 16, `baud_tick` pulses per bit period
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- baud_tick  in  1  one-clk strobe at 16x baud rate
- in_valid  in  1  `in_data` holds a byte to send
- in_data  in  DATA_BITS  byte to transmit; bit DATA_BITS-1 goes out first
- in_ready  out  1  block can accept a byte this cycle
- tx  out  1  serial line, registered, idles high
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse when the last stop bit ends

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1; `in_ready`=1; tick counter held at 0.
  - On `in_valid && in_ready`: latch `in_data` into the shift register and go to START.
  - `in_data` need not stay stable after acceptance.
- START:
  - `tx`=0.
  - Tick counter increments on each `baud_tick`.
  - When counter = OVERSAMPLE-1 and `baud_tick`=1: clear counter, go to DATA.
- DATA:
  - `tx` = shift register MSB.
  - At each bit end (counter = OVERSAMPLE-1 and `baud_tick`=1): shift left, bit counter +1.
  - After DATA_BITS bits, clear counters and go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS×OVERSAMPLE ticks.
  - At the end: go to IDLE and pulse `done` for that one cycle.
- `in_ready` = (state == IDLE) and not `rst`. `in_valid` while busy is ignored; the frame in flight is unaffected.
- Cycles with `baud_tick`=0 do not advance timing. All state and `tx` are held.
- A `baud_tick` in the accepting cycle is not counted; counting starts in START.
- Reset mid-frame aborts the frame:
  - Next cycle: `tx`=1, state IDLE, counters and shift register 0, no `done`.
- Reset values: `tx`=1, `in_ready`=1 (after reset deasserts), `busy`=0, `done`=0.

## Timing
- Acceptance to `tx` falling edge: 1 clk (`tx` registered).
- Start bit: exactly OVERSAMPLE `baud_tick` pulses, from the first tick after entering START to the clk edge after the OVERSAMPLE-th tick.
- Each data and stop bit is the same length.
- Frame = (1 + DATA_BITS + STOP_BITS) × OVERSAMPLE ticks; 8N1 at 16x = 160 ticks.
- `done` is asserted in the first IDLE cycle.
- Minimum gap between frames: 1 clk of IDLE. `tx` stays 1 through that cycle, and a held `in_valid` is accepted in it.
- `busy` rises the cycle after acceptance and falls in the same cycle `done` is asserted.

## Structure
- Shared package `uart_pkg`:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3 (shared with the receiver);
  - OVERSAMPLE default constant;
  - frame-length helper constant.
- Natural sub-module `uart_bit_timer`:
  - counts `baud_tick` modulo OVERSAMPLE;
  - outputs a `bit_end` strobe;
  - has synchronous clear;
  - is reusable by the receiver.
- Top level holds the FSM, shift register and bit counter.

## Test plan
- Reset held 2 cycles, then released:
  - `tx`=1, `in_ready`=1, `busy`=0, `done`=0;
  - `baud_tick` pulses in IDLE leave `tx` at 1.
- Send 0xA5 with `baud_tick` every 4 clk:
  - `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each held 16 ticks (64 clk);
  - `done` pulses once 640 clk after the start bit begins.
- Back-to-back 0x00 then 0xFF with `in_valid` held:
  - second byte accepted in the IDLE cycle at `done`;
  - `tx` high for 16 ticks + 1 clk between the frames;
  - both frames bit-exact.
- `in_valid` pulsed with 0x55 during a 0xC3 frame: 0xC3 transmitted unchanged, 0x55 not sent, `in_ready`=0 throughout.
- `rst` asserted during data bit 3 of 0x96:
  - next cycle `tx`=1, `busy`=0, no `done`;
  - a following 0x96 frame is transmitted correctly.
- Loopback into the team's receiver with 0x3C, 0x81, 0xFF: receiver output equals each byte after its stop bit.
